// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data load/store port onto one shared
// single-port memory, with data priority, fetch anti-starvation and a bus timeout.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                if_stall,
    output logic                d_stall,
    output logic                bus_err
);
    localparam int SC_W = $clog2(STARVE_MAX + 1);
    localparam int WC_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, GNT_IF, GNT_D} state_t;

    state_t          state_reg, state_next;
    logic [SC_W-1:0] starve_reg, starve_next;
    logic [WC_W-1:0] wait_reg, wait_next;

    logic ack_valid, timeout, done, arb;
    logic if_want, d_want, fetch_forced, grant_d, grant_if;
    logic [DATA_W-1:0] rdata_sel;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A requester is not eligible in its own rvalid cycle: its req is still the old transaction.
    always_comb begin
        ack_valid    = mem_ack && mem_req;
        timeout      = mem_req && !mem_ack && (wait_reg == WC_W'(TIMEOUT));
        done         = ack_valid || timeout;
        arb          = (state_reg == IDLE) || done;
        if_want      = if_req && !if_rvalid;
        d_want       = d_req && !d_rvalid;
        fetch_forced = if_want && (starve_reg == SC_W'(STARVE_MAX));
        grant_d      = arb && d_want && !fetch_forced;
        grant_if     = arb && if_want && !grant_d;
        rdata_sel    = ack_valid ? mem_rdata : '0;

        state_next  = state_reg;
        starve_next = starve_reg;
        wait_next   = wait_reg;
        if (arb) begin
            wait_next = '0;
            if (grant_d) begin
                state_next = GNT_D;
            end else if (grant_if) begin
                state_next = GNT_IF;
            end else begin
                state_next = IDLE;
            end
            if (grant_if || !if_want) begin
                starve_next = '0;
            end else if (grant_d && (starve_reg < SC_W'(STARVE_MAX))) begin
                starve_next = starve_reg + SC_W'(1);
            end
        end else if (mem_req && !mem_ack) begin
            wait_next = wait_reg + WC_W'(1);
        end
    end

    always_comb begin
        if_stall = if_req && !if_rvalid;
        d_stall  = d_req && !d_rvalid;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_reg <= '0;
            wait_reg   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            if_rvalid  <= 1'b0;
            d_rvalid   <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            bus_err    <= 1'b0;
        end else begin
            starve_reg <= starve_next;
            wait_reg   <= wait_next;
            mem_req    <= (state_next != IDLE);
            if (grant_d) begin
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_wstrb <= d_wstrb;
            end else if (grant_if) begin
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
                mem_wstrb <= '0;
            end
            if_rvalid <= done && (state_reg == GNT_IF);
            d_rvalid  <= done && (state_reg == GNT_D);
            if (done && (state_reg == GNT_IF)) begin
                if_rdata <= rdata_sel;
            end
            if (done && (state_reg == GNT_D)) begin
                d_rdata <= rdata_sel;
            end
            if (timeout) begin
                bus_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic, all
// checked cycle by cycle against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req, d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [3:0]        d_wstrb;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              if_stall, d_stall, bus_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .if_stall(if_stall), .d_stall(d_stall), .bus_err(bus_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Memory / requester behaviour knobs
    int          mem_lat;       // cycles of mem_req before ack; -1 = never ack
    bit          spur_ack;      // ack while no transaction is outstanding
    bit          use_fixed;
    logic [31:0] fixed_rdata;
    bit          if_oneshot, d_oneshot;

    // Reference model: owner 0 = none, 1 = fetch, 2 = data
    int          m_owner, m_wait, m_starve;
    bit          m_we, m_rv_if, m_rv_d, m_err;
    logic [31:0] m_addr, m_wdata, m_rdata_if, m_rdata_d;
    logic [3:0]  m_wstrb;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        int  fin;
        bit  fin_to, ackv, if_w, d_w;
        int  win;
        if (!reset) begin
            m_owner = 0; m_wait = 0; m_starve = 0; m_we = 0; m_addr = 0; m_wdata = 0;
            m_wstrb = 0; m_rv_if = 0; m_rv_d = 0; m_rdata_if = 0; m_rdata_d = 0; m_err = 0;
            return;
        end
        ackv   = mem_ack && (m_owner != 0);
        fin    = 0;
        fin_to = 0;
        if (m_owner != 0 && (ackv || m_wait == TIMEOUT)) begin
            fin    = m_owner;
            fin_to = !ackv;
        end
        if_w = if_req && !m_rv_if;
        d_w  = d_req && !m_rv_d;
        m_rv_if = (fin == 1);
        m_rv_d  = (fin == 2);
        if (fin == 1) m_rdata_if = fin_to ? 32'h0 : mem_rdata;
        if (fin == 2) m_rdata_d  = fin_to ? 32'h0 : mem_rdata;
        if (fin_to) m_err = 1;
        if (m_owner == 0 || fin != 0) begin
            if (if_w && m_starve == STARVE_MAX) win = 1;
            else if (d_w) win = 2;
            else if (if_w) win = 1;
            else win = 0;
            if (win == 1 || !if_w) m_starve = 0;
            else if (win == 2 && m_starve < STARVE_MAX) m_starve++;
            m_owner = win;
            m_wait  = 0;
            if (win == 1) begin
                m_we = 0; m_addr = if_addr; m_wdata = 0; m_wstrb = 0;
            end else if (win == 2) begin
                m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; m_wstrb = d_wstrb;
            end
        end else begin
            m_wait++;
        end
    endtask

    task automatic check_outputs();
        check_eq("mem_req", mem_req, m_owner != 0);
        if (m_owner != 0) begin
            check_eq("mem_addr", mem_addr, m_addr);
            check_eq("mem_we", mem_we, m_we);
            check_eq("mem_wstrb", mem_wstrb, m_wstrb);
            if (m_we) check_eq("mem_wdata", mem_wdata, m_wdata);
        end
        check_eq("if_rvalid", if_rvalid, m_rv_if);
        check_eq("d_rvalid", d_rvalid, m_rv_d);
        if (m_rv_if) begin
            check_eq("if_rdata", if_rdata, m_rdata_if);
            $display("txn fetch done rdata=%08h", if_rdata);
        end
        if (m_rv_d) begin
            check_eq("d_rdata", d_rdata, m_rdata_d);
            $display("txn data done rdata=%08h", d_rdata);
        end
        check_eq("bus_err", bus_err, m_err);
        check_eq("if_stall", if_stall, if_req && !m_rv_if);
        check_eq("d_stall", d_stall, d_req && !m_rv_d);
    endtask

    // One clock: memory response, edge, model update, output comparison at negedge.
    task automatic step();
        bit completing;
        if (m_owner != 0) mem_ack = (mem_lat >= 0) && (m_wait == mem_lat);
        else mem_ack = spur_ack;
        mem_rdata  = use_fixed ? fixed_rdata : $urandom;
        completing = (m_owner != 0) && (mem_ack || m_wait == TIMEOUT);
        if (completing && m_owner == 1 && if_oneshot) if_req = 0;
        if (completing && m_owner == 2 && d_oneshot) d_req = 0;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        reset = 0; if_req = 0; d_req = 0; spur_ack = 0;
        step();
        step();
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_if_rdata", if_rdata, 0);
        check_eq("rst_d_rdata", d_rdata, 0);
        reset = 1;
    endtask

    initial begin
        int cnt, pulses;
        bit seen;
        reset = 0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        d_wstrb = 0; mem_ack = 0; mem_rdata = 0; mem_lat = 0; spur_ack = 0;
        use_fixed = 0; fixed_rdata = 0; if_oneshot = 1; d_oneshot = 1;
        model_edge();
        @(negedge clk);

        // Fetch only, first grant right after reset release
        do_reset();
        if_req = 1; if_addr = 32'h10; mem_lat = 0; use_fixed = 1; fixed_rdata = 32'h0050_0093;
        step();
        check_eq("fetch_mem_req", mem_req, 1);
        check_eq("fetch_mem_we", mem_we, 0);
        check_eq("fetch_rvalid_early", if_rvalid, 0);
        step();
        check_eq("fetch_rvalid", if_rvalid, 1);
        check_eq("fetch_rdata", if_rdata, 32'h0050_0093);
        use_fixed = 0;
        step();

        // Simultaneous requests: data store first, fetch with no bubble
        do_reset();
        if_req = 1; if_addr = 32'h44;
        d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
        step();
        check_eq("sim_we", mem_we, 1);
        check_eq("sim_addr", mem_addr, 32'h100);
        check_eq("sim_wdata", mem_wdata, 32'hDEAD_BEEF);
        check_eq("sim_wstrb", mem_wstrb, 4'hF);
        step();
        check_eq("sim_d_rvalid", d_rvalid, 1);
        check_eq("sim_fetch_req", mem_req, 1);
        check_eq("sim_fetch_addr", mem_addr, 32'h44);
        step();
        check_eq("sim_if_rvalid", if_rvalid, 1);
        step();
        check_eq("sim_idle", mem_req, 0);

        // Starvation: held data loads vs waiting fetch
        do_reset();
        d_req = 1; d_we = 0; d_addr = 32'h200; d_oneshot = 0;
        if_req = 1; if_addr = 32'h40; mem_lat = 1;
        cnt = 0; seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            step();
            if (d_rvalid) cnt++;
            if (mem_req && mem_addr == 32'h40) seen = 1;
        end
        check_eq("starve_fetch_seen", seen, 1);
        check_eq("starve_data_grants", cnt, STARVE_MAX);
        d_oneshot = 1;
        for (int i = 0; i < 12; i++) step();
        check_eq("starve_drained", mem_req, 0);

        // Early drop of fetch request
        do_reset();
        if_req = 1; if_addr = 32'h20; if_oneshot = 0; mem_lat = 2;
        step();
        if_req = 0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (if_rvalid) pulses++;
        end
        check_eq("drop_pulses", pulses, 1);
        check_eq("drop_no_regrant", mem_req, 0);
        if_oneshot = 1;

        // Timeout on a load
        do_reset();
        d_req = 1; d_we = 0; d_addr = 32'h300; mem_lat = -1;
        step();
        check_eq("to_req_rise", mem_req, 1);
        cnt = 0;
        for (int i = 0; i < 40 && !d_rvalid; i++) begin
            step();
            cnt++;
        end
        check_eq("to_latency", cnt, TIMEOUT + 1);
        check_eq("to_rdata", d_rdata, 0);
        check_eq("to_bus_err", bus_err, 1);
        if_req = 1; if_addr = 32'h60; mem_lat = 0;
        for (int i = 0; i < 4; i++) step();
        check_eq("to_sticky", bus_err, 1);

        // Reset mid-transaction, then a late ack
        do_reset();
        if_req = 1; if_addr = 32'h80; mem_lat = -1;
        step(); step(); step();
        check_eq("rmt_busy", mem_req, 1);
        reset = 0; if_req = 0;
        step();
        check_eq("rmt_req_low", mem_req, 0);
        check_eq("rmt_no_rvalid", if_rvalid, 0);
        reset = 1; spur_ack = 1;
        step();
        check_eq("late_ack_rvalid", if_rvalid, 0);
        check_eq("late_ack_req", mem_req, 0);
        spur_ack = 0;
        step();
        check_eq("late_ack_rvalid2", if_rvalid, 0);

        // Random traffic
        if_oneshot = 0; d_oneshot = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!if_req) begin
                if ($urandom_range(2) == 0) begin if_req = 1; if_addr = $urandom; end
            end else if (m_rv_if) begin
                if ($urandom_range(1) == 1) if_req = 0; else if_addr = $urandom;
            end else if ($urandom_range(29) == 0) begin
                if_req = 0;
            end
            if (!d_req) begin
                if ($urandom_range(1) == 0) begin
                    d_req = 1; d_we = $urandom_range(1); d_addr = $urandom;
                    d_wdata = $urandom; d_wstrb = 4'($urandom_range(15));
                end
            end else if (m_rv_d) begin
                if ($urandom_range(1) == 1) d_req = 0;
                else begin d_addr = $urandom; d_we = $urandom_range(1); end
            end else if ($urandom_range(29) == 0) begin
                d_req = 0;
            end
            if (m_owner != 0 && m_wait == 0)
                mem_lat = ($urandom_range(19) == 0) ? -1 : int'($urandom_range(3));
            spur_ack = ($urandom_range(3) == 0);
            reset = ($urandom_range(299) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of both requesters and the memory port.
REQ-002 Parameter DATA_W, default 32, data width; the strobe width is DATA_W/8.
REQ-003 Parameter STARVE_MAX, default 4, maximum number of consecutive data grants while a fetch request waits.
REQ-004 Parameter TIMEOUT, default 15, maximum cycles mem_req stays high without mem_ack.
REQ-005 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 Port reset, input, 1, synchronous active-low reset (0 = reset), sampled on the rising edge of clk.
REQ-007 Port if_req, input, 1, instruction-fetch read request, held until if_rvalid.
REQ-008 Port if_addr, input, ADDR_W, fetch address.
REQ-009 Port if_rvalid, output, 1, one-cycle pulse; the fetch transaction is complete.
REQ-010 Port if_rdata, output, DATA_W, fetch data; valid while if_rvalid is 1.
REQ-011 Port d_req, input, 1, data load/store request, held until d_rvalid.
REQ-012 Port d_we, input, 1, 1 = store, 0 = load.
REQ-013 Port d_addr, input, ADDR_W, data address.
REQ-014 Port d_wdata, input, DATA_W, store data.
REQ-015 Port d_wstrb, input, DATA_W/8, store byte enables.
REQ-016 Port d_rvalid, output, 1, one-cycle pulse; the data transaction is complete.
REQ-017 Port d_rdata, output, DATA_W, load data; valid while d_rvalid is 1 and the transaction is a load.
REQ-018 Port mem_req, output, 1, request to the shared single-port memory.
REQ-019 Port mem_we, mem_addr, mem_wdata and mem_wstrb, outputs, 1/ADDR_W/DATA_W/DATA_W/8, registered command fields.
REQ-020 Port mem_ack, input, 1, memory completion; mem_rdata is valid in the same cycle.
REQ-021 Port mem_rdata, input, DATA_W, memory read data.
REQ-022 Port if_stall and d_stall, outputs, 1 each, combinational: req AND NOT rvalid.
REQ-023 Port bus_err, output, 1, sticky flag set when a transaction times out.

Function
REQ-024 FSM states SHALL be IDLE, GNT_IF and GNT_D.
REQ-025 Arbitration SHALL occur in IDLE, and in any granted state on the cycle mem_ack (or a timeout) occurs.
- This gives zero-bubble back-to-back grants.
REQ-026 Priority SHALL be data over fetch, except when starve_cnt == STARVE_MAX and if_req = 1: fetch wins.
REQ-027 starve_cnt SHALL behave as follows:
- increments on each data grant made while if_req = 1;
- clears on a fetch grant, or when if_req = 0 at arbitration;
- saturates at STARVE_MAX.
REQ-028 On a grant at edge N, the mem_* command fields SHALL be registered from the winner, and mem_req SHALL be 1 from cycle N+1.
- For a fetch grant, mem_we = 0 and mem_wstrb = 0.
REQ-029 mem_req and all mem_* command fields SHALL stay stable until the cycle mem_ack = 1 is sampled.
REQ-030 When mem_ack is sampled at edge M:
- owner rvalid = 1 and rdata = mem_rdata (registered) during cycle M+1;
- mem_req drops at M+1 unless a new grant is made at M.
REQ-031 The minimum request-to-rvalid latency SHALL be 2 cycles: request sampled at N, mem_ack at N+1, rvalid at N+2.
REQ-032 A transaction SHALL not be re-granted to the same requester in the cycle its rvalid is high.
- Req is still high in that cycle, so it must not count as a new request.
REQ-033 mem_ack while mem_req = 0 SHALL be ignored.
REQ-034 Timeout: a wait counter increments each cycle mem_req = 1 and mem_ack = 0. When it reaches TIMEOUT, the arbiter SHALL:
- pulse the owner's rvalid with rdata = 0;
- set bus_err;
- re-arbitrate.
REQ-035 A requester dropping req before rvalid SHALL NOT abort the transaction; rvalid still pulses.
REQ-036 if_req and d_req rising in the same IDLE cycle SHALL grant data first, then fetch on that data transaction's ack cycle.

Reset
REQ-037 While reset = 0 at a clk edge, the following SHALL clear: state = IDLE, mem_req = 0, all mem_* fields = 0, if_rvalid = d_rvalid = 0, rdata outputs = 0, starve_cnt = 0, wait counter = 0, bus_err = 0.
REQ-038 Reset asserted mid-transaction SHALL abandon it with no rvalid pulse.
- A mem_ack arriving after reset releases is ignored per REQ-033.
REQ-039 The first grant after reset release SHALL be evaluated on the first edge with reset = 1.

Verification
REQ-040 Fetch only: if_addr = 0x0000_0010, memory acks 1 cycle after mem_req with rdata 0x0050_0093 -> if_rvalid at request+2, if_rdata = 0x0050_0093, mem_we = 0.
REQ-041 Simultaneous requests: if_req and d_req (store 0xDEAD_BEEF to 0x100, wstrb 0xF) -> data granted first, d_rvalid, then fetch with no idle cycle between them.
REQ-042 Starvation: d_req held high with back-to-back loads, if_req high -> fetch granted after exactly 4 data grants, starve_cnt back to 0.
REQ-043 Timeout: memory never acks a load -> d_rvalid 16 cycles after mem_req rises (15 wait cycles plus registered pulse), d_rdata = 0, bus_err = 1 and sticky.
REQ-044 Reset mid-transaction: reset = 0 while mem_req = 1 -> next cycle mem_req = 0 and state IDLE; a late mem_ack after release produces no rvalid.
REQ-045 Early drop: fetch issued, if_req deasserted before ack -> if_rvalid still pulses once and no extra grant follows.
